stream_mux_1ofn: RTL and testbench

Registered N-to-1 streaming multiplexer with per-port valid/ready handshake, selectable explicit-select or round-robin arbitration, and a 2-entry output skid buffer. It is the successor of the plain registered select mux. It sits between parallel alignment/processing lanes and a single downstream consumer that may apply back-pressure. Full throughput is one beat per cycle.

---
 rtl/stream_mux_1ofn.sv | 159 +++++++++++++++
 tb/tb_stream_mux_1ofn.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_1ofn.sv
// stream_mux_1ofn: registered N-to-1 stream mux with per-port valid/ready,
// explicit-select or round-robin arbitration and a 2-entry output skid buffer.
// Optional feature macro: STREAM_MUX_PKT_LOCK_EN (hold the grant for a whole packet).
module stream_mux_1ofn #(
    parameter int unsigned NUM_PORTS_WIDTH = 2,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        mode,
    input  logic [NUM_PORTS_WIDTH-1:0]                  select,
    input  logic [(1<<NUM_PORTS_WIDTH)-1:0]             in_valid,
    input  logic [(1<<NUM_PORTS_WIDTH)*DATA_WIDTH-1:0]  in_data,
    input  logic [(1<<NUM_PORTS_WIDTH)-1:0]             in_last,
    output logic [(1<<NUM_PORTS_WIDTH)-1:0]             in_ready,
    output logic                                        out_valid,
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic                                        out_last,
    output logic [NUM_PORTS_WIDTH-1:0]                  out_port,
    input  logic                                        out_ready
);

    localparam int unsigned PW        = NUM_PORTS_WIDTH;
    localparam int unsigned NUM_PORTS = 1 << NUM_PORTS_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [PW-1:0]         port;
    } beat_t;

    logic [1:0]           r_count;
    beat_t                r_head;
    beat_t                r_tail;
    logic [PW-1:0]        r_rr_last;

    logic [PW-1:0]        w_rr_grant;
    logic                 w_rr_found;
    logic [PW-1:0]        w_grant;
    logic                 w_grant_vld;
    logic [NUM_PORTS-1:0] w_in_ready;
    logic                 w_accept;
    logic                 w_pop;
    beat_t                w_push_beat;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic                 r_locked;
    logic [PW-1:0]        r_lock_port;
`endif

    // Round-robin scan: first valid port after r_rr_last, wrapping modulo NUM_PORTS
    always_comb begin
        logic [PW-1:0] idx;
        w_rr_grant = '0;
        w_rr_found = 1'b0;
        idx        = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = PW'(r_rr_last + PW'(i));
            if (!w_rr_found && in_valid[idx]) begin
                w_rr_found = 1'b1;
                w_rr_grant = idx;
            end
        end
    end

    // Grant selection; an open packet lock overrides both modes
    always_comb begin
        w_grant     = select;
        w_grant_vld = 1'b1;
        if (mode) begin
            w_grant     = w_rr_grant;
            w_grant_vld = w_rr_found;
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (r_locked) begin
            w_grant     = r_lock_port;
            w_grant_vld = 1'b1;
        end
`endif
    end

    // One-hot ready from registered occupancy only; held low while in reset
    always_comb begin
        w_in_ready = '0;
        if (rst_n && w_grant_vld && (r_count != 2'd2)) begin
            w_in_ready[w_grant] = 1'b1;
        end
    end

    assign in_ready = w_in_ready;
    assign w_accept = |(w_in_ready & in_valid);
    assign w_pop    = (r_count != 2'd0) && out_ready;

    assign w_push_beat.data = in_data[w_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_push_beat.last = in_last[w_grant];
    assign w_push_beat.port = w_grant;

    // Skid buffer: head feeds the outputs, tail only holds a second beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head <= r_tail;
                end else if (w_accept) begin
                    r_head <= w_push_beat;
                end
            end else if (w_accept) begin
                if (r_count == 2'd0) begin
                    r_head <= w_push_beat;
                end else begin
                    r_tail <= w_push_beat;
                end
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Lock onto the source of a non-final beat; release and advance pointer on its last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last   <= PW'(NUM_PORTS - 1);
            r_locked    <= 1'b0;
            r_lock_port <= '0;
        end else if (w_accept) begin
            if (!w_push_beat.last) begin
                r_locked    <= 1'b1;
                r_lock_port <= w_grant;
            end else begin
                r_locked  <= 1'b0;
                r_rr_last <= w_grant;
            end
        end
    end
`else
    // Per-beat arbitration: pointer follows every accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= PW'(NUM_PORTS - 1);
        end else if (w_accept) begin
            r_rr_last <= w_grant;
        end
    end
`endif

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_head.data;
    assign out_last  = r_head.last;
    assign out_port  = r_head.port;

endmodule

// File: tb/tb_stream_mux_1ofn.sv
// Scoreboard bench for stream_mux_1ofn: directed stimulus pushes hand-computed
// expected beats; a negedge monitor pops and compares every output handshake.
module tb_stream_mux_1ofn;

    localparam int unsigned NPW   = 2;
    localparam int unsigned NP    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 160;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic           last;
        logic [NPW-1:0] port;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              mode;
    logic [NPW-1:0]    select;
    logic [NP-1:0]     in_valid;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     in_last;
    logic [NP-1:0]     in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [NPW-1:0]    out_port;
    logic              out_ready;

    exp_t          sb[$];
    int            checks;
    int            errors;
    logic [DW-1:0] src_d [NP][DEPTH];
    logic          src_l [NP][DEPTH];
    int            src_n [NP];
    int            src_i [NP];
    logic          ov_s;
    logic [NP-1:0] ir_s;

    stream_mux_1ofn #(.NUM_PORTS_WIDTH(NPW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .select    (select),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_port  (out_port),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every output handshake must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got data=%h last=%b port=%0d with empty scoreboard",
                         out_data, out_last, out_port);
            end else begin
                e = sb.pop_front();
                if ({out_data, out_last, out_port} !== e) begin
                    errors++;
                    $display("FAIL beat got data=%h last=%b port=%0d want data=%h last=%b port=%0d",
                             out_data, out_last, out_port, e.data, e.last, e.port);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (src_i[p] < src_n[p]) begin
                in_valid[p]         = 1'b1;
                in_data[p*DW +: DW] = src_d[p][src_i[p]];
                in_last[p]          = src_l[p][src_i[p]];
            end else begin
                in_valid[p]         = 1'b0;
                in_data[p*DW +: DW] = '0;
                in_last[p]          = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [NP-1:0] acc;
        @(negedge clk);
        ov_s = out_valid;
        ir_s = in_ready;
        acc  = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) src_i[p]++;
        end
        drive();
    endtask

    task automatic load(input int p, input logic [DW-1:0] d, input logic l);
        src_d[p][src_n[p]] = d;
        src_l[p][src_n[p]] = l;
        src_n[p]++;
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic l, input int p);
        exp_t e;
        e.data = d;
        e.last = l;
        e.port = NPW'(p);
        sb.push_back(e);
    endtask

    task automatic clear_src();
        for (int p = 0; p < NP; p++) begin
            src_n[p] = 0;
            src_i[p] = 0;
        end
        drive();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle got %0d beats pending want 0", sb.size());
            sb.delete();
        end
        step();
    endtask

    initial begin
        int ones;
        int bubbles;
        int drops;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        select    = '0;
        out_ready = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        clear_src();

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out_port",  64'(out_port),  64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Explicit select: port 2 only, one beat per cycle
        mode = 1'b0;
        select = 2'd2;
        out_ready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 4; k++) begin
                load(p, 32'hA5A5_0000 | (32'(k) << 12) | 32'(p), 1'b1);
            end
        end
        for (int k = 0; k < 4; k++) expect_beat(32'hA5A5_0002 | (32'(k) << 12), 1'b1, 2);
        drive();
        #1;
        check("sel_in_ready", 64'(in_ready), 64'b0100);
        step();
        ones = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ov_s) ones++;
        end
        check("sel_throughput", 64'(ones), 64'd4);
        clear_src();
        wait_idle(20);

        // Back-pressure: two accepts then stall, drain in order
        mode = 1'b0;
        select = 2'd1;
        out_ready = 1'b0;
        load(1, 32'h10, 1'b1);
        load(1, 32'h11, 1'b1);
        load(1, 32'h12, 1'b1);
        expect_beat(32'h10, 1'b1, 1);
        expect_beat(32'h11, 1'b1, 1);
        expect_beat(32'h12, 1'b1, 1);
        drive();
        repeat (4) step();
        check("bp_accepts",   64'(src_i[1]),  64'd2);
        check("bp_in_ready",  64'(in_ready),  64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head_data", 64'(out_data),  64'h10);
        out_ready = 1'b1;
        wait_idle(20);
        clear_src();

        // Two simultaneous 3-beat packets on ports 0 and 1
        mode = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load(0, 32'hA0 + 32'(k), k == 2);
            load(1, 32'hB0 + 32'(k), k == 2);
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        for (int k = 0; k < 3; k++) expect_beat(32'hA0 + 32'(k), k == 2, 0);
        for (int k = 0; k < 3; k++) expect_beat(32'hB0 + 32'(k), k == 2, 1);
`else
        for (int k = 0; k < 3; k++) begin
            expect_beat(32'hA0 + 32'(k), k == 2, 0);
            expect_beat(32'hB0 + 32'(k), k == 2, 1);
        end
`endif
        drive();
        wait_idle(30);
        clear_src();

        // Continuous source with out_ready=1: no bubbles, ready never drops
        mode = 1'b0;
        select = 2'd2;
        out_ready = 1'b1;
        for (int k = 0; k < 120; k++) begin
            load(2, 32'h1000 + 32'(k), (k % 4) == 3);
            expect_beat(32'h1000 + 32'(k), (k % 4) == 3, 2);
        end
        drive();
        step();
        bubbles = 0;
        drops = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (!ov_s) bubbles++;
            if (!ir_s[2]) drops++;
        end
        check("pp_bubbles",     64'(bubbles), 64'd0);
        check("pp_ready_drops", 64'(drops),   64'd0);
        wait_idle(60);
        clear_src();

        // Reset with a full buffer: beats discarded, port 0 wins afterwards
        mode = 1'b0;
        select = 2'd3;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) load(3, 32'hDEAD_0000 + 32'(k), 1'b1);
        drive();
        repeat (3) step();
        check("mr_full_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_in_ready",  64'(in_ready),  64'd0);
        clear_src();
        mode = 1'b1;
        out_ready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            load(p, 32'hC0DE_0000 + 32'(p), 1'b1);
            expect_beat(32'hC0DE_0000 + 32'(p), 1'b1, p);
        end
        drive();
        step();
        rst_n = 1'b1;
        #1;
        check("mr_first_grant", 64'(in_ready), 64'b0001);
        wait_idle(20);
        clear_src();

        // Round-robin with port 2 idle
        mode = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            load(0, 32'hBB00_0000 + 32'(k), 1'b1);
            load(1, 32'hBB00_0010 + 32'(k), 1'b1);
            load(3, 32'hBB00_0030 + 32'(k), 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            expect_beat(32'hBB00_0000 + 32'(k), 1'b1, 0);
            expect_beat(32'hBB00_0010 + 32'(k), 1'b1, 1);
            expect_beat(32'hBB00_0030 + 32'(k), 1'b1, 3);
        end
        drive();
        wait_idle(30);
        check("end_out_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
